// File: rtl/hazard_controller.sv
// hazard_controller
//   Pipeline hazard unit for a 5-stage in-order core. It detects load-use
//   hazards, flushes after a taken branch and freezes the pipe while a
//   data-memory request is outstanding. A sticky error flag sets if the
//   memory request stays unanswered too long.
//
// Parameters
//   FLUSH_CYCLES  cycles ifid_flush/idex_bubble stay high per taken branch (1-3)
//   MEM_TIMEOUT   unanswered freeze cycles before mem_err sets (1-255)
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   id_opcode/rs1/rs2     IF/ID instruction fields
//   ex_mem_read, ex_rd    load indication / destination of ID/EX instruction
//   ex_branch_taken       branch in EX resolved taken
//   mem_req, mem_ready    MEM-stage handshake (req & !ready = freeze)
//   pc_write, ifid_write  PC / IF/ID update enables
//   ifid_flush            IF/ID clear to NOP
//   idex_bubble           zero control into ID/EX
//   exmem_hold            hold EX/MEM and MEM/WB
//   mem_err               sticky memory timeout
//   state_o               0 RUN, 1 LSTALL, 2 FLUSH
//   stall_cnt, flush_cnt  event counters, only with HAZARD_PERF_CNT_EN defined
module hazard_controller #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] id_opcode,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       ex_branch_taken,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic       exmem_hold,
  output logic       mem_err,
  output logic [1:0] state_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_LSTALL = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;

  localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);
  localparam logic [7:0] TIMEOUT    = 8'(MEM_TIMEOUT);

  logic [1:0] state_q, state_d;
  logic [1:0] fcnt_q, fcnt_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic       mem_err_q, mem_err_d;
  logic       flush_prev_q, flush_prev_d;
  logic       bub_prev_q, bub_prev_d;

  logic freeze, rs1_used, rs2_used, hazard;
  logic pc_c, ifw_c, flush_c, bub_c, hold_c;

  assign freeze = mem_req & ~mem_ready;

  always_comb begin
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    case (id_opcode)
      7'b0110011, 7'b0100011, 7'b1100011: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      7'b0000011, 7'b0010011: rs1_used = 1'b1;
      default: ;
    endcase
  end

  assign hazard = ex_mem_read & (ex_rd != 5'd0) &
                  ((rs1_used & (ex_rd == id_rs1)) | (rs2_used & (ex_rd == id_rs2)));

  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    pc_c      = 1'b1;
    ifw_c     = 1'b1;
    flush_c   = 1'b0;
    bub_c     = 1'b0;
    hold_c    = 1'b0;
    // Counter saturates so a long freeze with MEM_TIMEOUT=255 cannot wrap.
    tcnt_d    = freeze ? ((tcnt_q == 8'hFF) ? tcnt_q : tcnt_q + 8'd1) : 8'd0;
    mem_err_d = mem_err_q | (tcnt_q == TIMEOUT);

    if (freeze) begin
      // Everything holds; flush/bubble repeat whatever they showed last cycle.
      pc_c    = 1'b0;
      ifw_c   = 1'b0;
      hold_c  = 1'b1;
      flush_c = flush_prev_q;
      bub_c   = bub_prev_q;
    end else if (ex_branch_taken) begin
      flush_c = 1'b1;
      bub_c   = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = ST_FLUSH;
        fcnt_d  = FLUSH_INIT;
      end else begin
        state_d = ST_RUN;
        fcnt_d  = 2'd0;
      end
    end else begin
      case (state_q)
        ST_FLUSH: begin
          flush_c = 1'b1;
          bub_c   = 1'b1;
          if (fcnt_q <= 2'd1) begin
            state_d = ST_RUN;
            fcnt_d  = 2'd0;
          end else begin
            fcnt_d = fcnt_q - 2'd1;
          end
        end
        ST_LSTALL: state_d = ST_RUN;
        default: begin
          if (hazard) begin
            pc_c    = 1'b0;
            ifw_c   = 1'b0;
            bub_c   = 1'b1;
            state_d = ST_LSTALL;
          end
        end
      endcase
    end

    flush_prev_d = flush_c;
    bub_prev_d   = bub_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RUN;
      fcnt_q       <= 2'd0;
      tcnt_q       <= 8'd0;
      mem_err_q    <= 1'b0;
      flush_prev_q <= 1'b0;
      bub_prev_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      fcnt_q       <= fcnt_d;
      tcnt_q       <= tcnt_d;
      mem_err_q    <= mem_err_d;
      flush_prev_q <= flush_prev_d;
      bub_prev_q   <= bub_prev_d;
    end
  end

  // Reset forces the pipe into a flushed, non-advancing condition.
  assign pc_write    = reset ? 1'b0 : pc_c;
  assign ifid_write  = reset ? 1'b0 : ifw_c;
  assign ifid_flush  = reset ? 1'b1 : flush_c;
  assign idex_bubble = reset ? 1'b1 : bub_c;
  assign exmem_hold  = reset ? 1'b0 : hold_c;
  assign mem_err     = mem_err_q;
  assign state_o     = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;
  logic        stall_evt, flush_evt;

  assign stall_evt = ~freeze & ~ex_branch_taken & (state_q == ST_RUN) & hazard;
  assign flush_evt = ~freeze & ex_branch_taken;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (stall_evt && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (flush_evt && flush_cnt_q != 16'hFFFF) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;
  localparam int FC = 2;
  localparam int MT = 4;

  localparam logic [6:0] OP_ADD  = 7'b0110011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] id_opcode = '0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       ex_mem_read = 1'b0, ex_branch_taken = 1'b0;
  logic       mem_req = 1'b0, mem_ready = 1'b0;
  logic       pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold, mem_err;
  logic [1:0] state_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  hazard_controller #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT)) dut (
    .clk(clk), .reset(reset),
    .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .exmem_hold(exmem_hold), .mem_err(mem_err),
    .state_o(state_o)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model: remaining flush cycles, stall bookkeeping, freeze run length.
  int m_flush_left = 0;
  bit m_stalled = 0;
  bit m_prev_fl = 0, m_prev_bub = 0;
  int m_fz_run = 0;
  bit m_err = 0;
  int m_stalls = 0, m_flushes = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic bit uses_rs1(input logic [6:0] op);
    return (op == OP_ADD) || (op == OP_LW) || (op == OP_SW) || (op == OP_ADDI) || (op == OP_BR);
  endfunction

  function automatic bit uses_rs2(input logic [6:0] op);
    return (op == OP_ADD) || (op == OP_SW) || (op == OP_BR);
  endfunction

  task automatic step(input bit r, input logic [6:0] op, input logic [4:0] a, input logic [4:0] b,
                      input bit mr, input logic [4:0] rd, input bit br, input bit rq, input bit rdy);
    bit fz, hz;
    int e_pc, e_ifw, e_fl, e_bub, e_hold, e_st, e_err;
    @(negedge clk);
    reset = r; id_opcode = op; id_rs1 = a; id_rs2 = b;
    ex_mem_read = mr; ex_rd = rd; ex_branch_taken = br; mem_req = rq; mem_ready = rdy;
    #1;
    fz = rq && !rdy;
    hz = mr && (rd != 0) && ((uses_rs1(op) && rd == a) || (uses_rs2(op) && rd == b));
    if (r) begin
      e_pc = 0; e_ifw = 0; e_fl = 1; e_bub = 1; e_hold = 0; e_st = 0; e_err = 0;
    end else begin
      e_err = m_err;
      e_st = (m_flush_left > 0) ? 2 : (m_stalled ? 1 : 0);
      e_pc = 1; e_ifw = 1; e_fl = 0; e_bub = 0; e_hold = 0;
      if (fz) begin
        e_pc = 0; e_ifw = 0; e_hold = 1; e_fl = m_prev_fl; e_bub = m_prev_bub;
      end else if (br) begin
        e_fl = 1; e_bub = 1;
      end else if (m_flush_left > 0) begin
        e_fl = 1; e_bub = 1;
      end else if (!m_stalled && hz) begin
        e_pc = 0; e_ifw = 0; e_bub = 1;
      end
    end
    chk("pc_write", pc_write, e_pc);
    chk("ifid_write", ifid_write, e_ifw);
    chk("ifid_flush", ifid_flush, e_fl);
    chk("idex_bubble", idex_bubble, e_bub);
    chk("exmem_hold", exmem_hold, e_hold);
    chk("mem_err", mem_err, e_err);
    chk("state_o", state_o, e_st);
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_cnt", stall_cnt, r ? 0 : m_stalls);
    chk("flush_cnt", flush_cnt, r ? 0 : m_flushes);
`endif
    if (r) begin
      m_flush_left = 0; m_stalled = 0; m_prev_fl = 0; m_prev_bub = 0;
      m_fz_run = 0; m_err = 0; m_stalls = 0; m_flushes = 0;
    end else begin
      if (!fz) begin
        if (br) begin
          m_flush_left = FC - 1; m_stalled = 0;
          if (m_flushes < 65535) m_flushes++;
        end else if (m_flush_left > 0) begin
          m_flush_left--;
        end else if (!m_stalled && hz) begin
          m_stalled = 1;
          if (m_stalls < 65535) m_stalls++;
        end else begin
          m_stalled = 0;
        end
      end
      m_err = m_err || (m_fz_run == MT);
      m_fz_run = fz ? ((m_fz_run < 255) ? m_fz_run + 1 : 255) : 0;
      m_prev_fl = e_fl[0];
      m_prev_bub = e_bub[0];
    end
  endtask

  task automatic idle();
    step(0, OP_LUI, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
  endtask

  task automatic frz();
    step(0, OP_LUI, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0);
  endtask

  logic [6:0] ops [6];
  int burst = 0;

  initial begin
    ops[0] = OP_ADD; ops[1] = OP_LW; ops[2] = OP_SW;
    ops[3] = OP_ADDI; ops[4] = OP_BR; ops[5] = OP_LUI;

    // Reset values
    step(1, OP_LUI, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    step(1, OP_LUI, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    chk("rst_flush", ifid_flush, 1);
    chk("rst_pc", pc_write, 0);
    idle();
    chk("post_rst_pc", pc_write, 1);
    chk("post_rst_flush", ifid_flush, 0);

    // lw x5 ; add x6,x5,x7 (hazard held through LSTALL to show masking)
    step(0, OP_ADD, 5'd5, 5'd7, 1, 5'd5, 0, 0, 1);
    chk("lu_pc", pc_write, 0);
    chk("lu_ifw", ifid_write, 0);
    chk("lu_bub", idex_bubble, 1);
    step(0, OP_ADD, 5'd5, 5'd7, 1, 5'd5, 0, 0, 1);
    chk("lstall_state", state_o, 1);
    chk("lstall_pc", pc_write, 1);
    idle();
    chk("lstall_back", state_o, 0);

    // addi x6,x0,1 with rs2 field = 5 -> no stall ; ex_rd = 0 -> no stall
    step(0, OP_ADDI, 5'd0, 5'd5, 1, 5'd5, 0, 0, 0);
    chk("addi_pc", pc_write, 1);
    step(0, OP_ADD, 5'd0, 5'd0, 1, 5'd0, 0, 0, 0);
    chk("rd0_pc", pc_write, 1);
    idle();

    // Branch pulse -> 2 flush cycles
    step(0, OP_LUI, 5'd0, 5'd0, 0, 5'd0, 1, 0, 0);
    chk("br_fl0", ifid_flush, 1);
    idle();
    chk("br_fl1", ifid_flush, 1);
    chk("br_st1", state_o, 2);
    idle();
    chk("br_fl2", ifid_flush, 0);

    // Branch with simultaneous hazard -> no LSTALL
    step(0, OP_ADD, 5'd5, 5'd7, 1, 5'd5, 1, 0, 0);
    chk("brhz_pc", pc_write, 1);
    step(0, OP_ADD, 5'd5, 5'd7, 1, 5'd5, 0, 0, 0);
    chk("brhz_st", state_o, 2);
    idle();
    chk("brhz_end", state_o, 0);

    // Freeze for 3 cycles in FLUSH extends it
    step(0, OP_LUI, 5'd0, 5'd0, 0, 5'd0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      frz();
      chk("fzfl_hold", exmem_hold, 1);
      chk("fzfl_flush", ifid_flush, 1);
    end
    idle();
    chk("fzfl_tail", ifid_flush, 1);
    idle();
    chk("fzfl_done", ifid_flush, 0);

    // Timeout with MEM_TIMEOUT=4
    for (int i = 1; i <= 6; i++) begin
      frz();
      if (i == 5) chk("to_err5", mem_err, 0);
    end
    chk("to_err6", mem_err, 1);
    idle(); idle();
    chk("to_sticky", mem_err, 1);
    step(1, OP_LUI, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    chk("to_rst", mem_err, 0);
    idle();

    // Reset mid-FLUSH
    step(0, OP_LUI, 5'd0, 5'd0, 0, 5'd0, 1, 0, 0);
    step(1, OP_LUI, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    chk("rstfl_state", state_o, 0);
    chk("rstfl_bub", idex_bubble, 1);
    idle();
    chk("rstfl_after_fl", ifid_flush, 0);
    chk("rstfl_after_pc", pc_write, 1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit r, mr, br, rq, rdy, fz;
      logic [6:0] op;
      logic [4:0] a, b, rd;
      r  = ($urandom_range(0, 199) == 0);
      op = ops[$urandom_range(0, 5)];
      a  = 5'($urandom_range(0, 3));
      b  = 5'($urandom_range(0, 3));
      rd = 5'($urandom_range(0, 3));
      mr = ($urandom_range(0, 2) != 0);
      br = ($urandom_range(0, 7) == 0);
      if (burst == 0 && $urandom_range(0, 29) == 0) burst = $urandom_range(1, 8);
      fz = (burst > 0) || ($urandom_range(0, 9) == 0);
      if (burst > 0) burst--;
      rq  = fz ? 1'b1 : 1'($urandom_range(0, 1));
      rdy = fz ? 1'b0 : (rq ? 1'b1 : 1'($urandom_range(0, 1)));
      step(r, op, a, b, mr, rd, br, rq, rdy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
